// File: rtl/apcpu_pkg.sv
// Shared bus definitions for the GP register file data bus: opcodes, responder
// FSM states and the word returned for out-of-range reads.
package apcpu_pkg;

    localparam logic [1:0] MEM_NOP    = 2'b00;
    localparam logic [1:0] MEM_RD     = 2'b01;
    localparam logic [1:0] MEM_WR     = 2'b10;
    localparam logic [1:0] MEM_TO_GPR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ACK  = 2'b10
    } state_e;

    localparam logic [31:0] MEM_ERR_WORD = 32'hDEAD_BEEF;

    function automatic logic is_mem_req(input logic [1:0] op);
        return (op == MEM_RD) || (op == MEM_WR);
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Data bus between the register file / control unit (master) and the
// memory responder (slave).
interface data_mem_responder_if #(
    parameter int ADDR_W = 8
);
    logic [1:0]        MemInstruction;
    logic [ADDR_W-1:0] Addr;
    logic [31:0]       WrData;
    logic [31:0]       MemData;
    logic              DataACKOut;
    logic              Busy;
    logic              Err;

    modport master (
        output MemInstruction, Addr, WrData,
        input  MemData, DataACKOut, Busy, Err
    );

    modport slave (
        input  MemInstruction, Addr, WrData,
        output MemData, DataACKOut, Busy, Err
    );
endinterface

// File: rtl/data_mem_responder_dmem_array.sv
// Single-port synchronous word RAM with write enable and registered read.
// Contents are deliberately not reset.
module dmem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    // Storage write and registered read port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: services read/write requests with a fixed latency and a
// four-phase acknowledge. Optional range checking under MEMRESP_RANGE_CHECK_EN.
module data_mem_responder
    import apcpu_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    data_mem_responder_if.slave  bus
);
    localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       mem_data_q, mem_data_d;
    logic              ack_q, ack_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic              ram_we_s;
    logic [ADDR_W-1:0] req_addr_s;
    logic [RAM_AW-1:0] ram_addr_s;
    logic [31:0]       ram_rdata_s;
    logic              oor_s;

    function automatic logic [RAM_AW-1:0] wrap_addr(input logic [ADDR_W-1:0] a);
        logic [31:0] m;
        m = 32'(a) % 32'(DEPTH);
        return m[RAM_AW-1:0];
    endfunction

    // In IDLE the RAM reads the live bus address so read data is ready even at LATENCY=1.
    always_comb begin
        req_addr_s = (state_q == ST_IDLE) ? bus.Addr : addr_q;
        ram_addr_s = wrap_addr(req_addr_s);
`ifdef MEMRESP_RANGE_CHECK_EN
        oor_s = (32'(addr_q) >= 32'(DEPTH));
`else
        oor_s = 1'b0;
`endif
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (RAM_AW)
    ) u_dmem_array (
        .clk   (clk),
        .we    (ram_we_s),
        .addr  (ram_addr_s),
        .wdata (wdata_q),
        .rdata (ram_rdata_s)
    );

    // Next-state and output logic for the IDLE -> WAIT -> ACK handshake.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        mem_data_d = mem_data_q;
        ack_d      = ack_q;
        err_d      = err_q;
        ram_we_s   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (is_mem_req(bus.MemInstruction)) begin
                    op_d    = bus.MemInstruction;
                    addr_d  = bus.Addr;
                    wdata_d = bus.WrData;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    if (op_q == MEM_WR) begin
                        ram_we_s = !oor_s;
                    end else begin
                        mem_data_d = oor_s ? MEM_ERR_WORD : ram_rdata_s;
                    end
                    ack_d   = 1'b1;
                    err_d   = oor_s;
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACK: begin
                if (bus.MemInstruction == MEM_NOP) begin
                    ack_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ACK;
                end
            end
            default: begin
                ack_d   = 1'b0;
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            op_q       <= MEM_NOP;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            mem_data_q <= 32'd0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            mem_data_q <= mem_data_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign bus.MemData    = mem_data_q;
    assign bus.DataACKOut = ack_q;
    assign bus.Busy       = busy_q;
    assign bus.Err        = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (DEPTH=256, ADDR_W=9, LATENCY=3).
module tb_data_mem_responder;
    import apcpu_pkg::*;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    data_mem_responder_if #(.ADDR_W(9)) bus ();

    data_mem_responder #(
        .DEPTH   (256),
        .ADDR_W  (9),
        .LATENCY (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request, wait (bounded) for ack, then return to NOP for one edge.
    task automatic do_access(input logic [1:0] op, input logic [8:0] a, input logic [31:0] d,
                             output int lat, output logic [31:0] data, output logic err);
        bus.MemInstruction = op;
        bus.Addr           = a;
        bus.WrData         = d;
        lat                = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus.DataACKOut === 1'b1) begin
                lat = i - 1;
                break;
            end
        end
        data = bus.MemData;
        err  = bus.Err;
        bus.MemInstruction = MEM_NOP;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        int lat; logic [31:0] data; logic err;
        rst_n = 1'b0;
        bus.MemInstruction = MEM_NOP; bus.Addr = 9'd0; bus.WrData = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.MemData !== 32'd0) begin errors++; $display("FAIL reset_memdata got %h want %h", bus.MemData, 32'd0); end
        checks++; if (bus.DataACKOut !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", bus.DataACKOut); end
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.Busy); end
        checks++; if (bus.Err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.Err); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_access(MEM_WR, 9'h005, 32'h1111_1111, lat, data, err);
        bus.MemInstruction = MEM_WR; bus.Addr = 9'h005; bus.WrData = 32'hAAAA_5555;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", bus.Busy); end
        checks++; if (bus.DataACKOut !== 1'b0) begin errors++; $display("FAIL abort_ack got %b want 0", bus.DataACKOut); end
        bus.MemInstruction = MEM_NOP;
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.DataACKOut !== 1'b0) begin errors++; $display("FAIL abort_no_ack got %b want 0", bus.DataACKOut); end
        do_access(MEM_RD, 9'h005, 32'd0, lat, data, err);
        checks++; if (data !== 32'h1111_1111) begin errors++; $display("FAIL abort_no_write got %h want %h", data, 32'h1111_1111); end
    endtask

    task automatic test_write_read();
        int lat; logic [31:0] data; logic err;
        do_access(MEM_WR, 9'h010, 32'h1234_5678, lat, data, err);
        checks++; if (lat !== 3) begin errors++; $display("FAIL wr_latency got %0d want 3", lat); end
        checks++; if (data !== 32'h1111_1111) begin errors++; $display("FAIL wr_keeps_memdata got %h want %h", data, 32'h1111_1111); end
        do_access(MEM_WR, 9'h020, 32'h2222_2222, lat, data, err);
        do_access(MEM_RD, 9'h010, 32'd0, lat, data, err);
        checks++; if (data !== 32'h1234_5678) begin errors++; $display("FAIL rd_data got %h want %h", data, 32'h1234_5678); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL rd_latency got %0d want 3", lat); end
    endtask

    task automatic test_latency();
        logic [3:0] exp_ack;
        exp_ack = 4'b1000;
        bus.MemInstruction = MEM_RD; bus.Addr = 9'h020;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++; if (bus.DataACKOut !== exp_ack[i]) begin errors++; $display("FAIL lat_ack_edge%0d got %b want %b", i, bus.DataACKOut, exp_ack[i]); end
            checks++; if (bus.Busy !== 1'b1) begin errors++; $display("FAIL lat_busy_edge%0d got %b want 1", i, bus.Busy); end
        end
        checks++; if (bus.MemData !== 32'h2222_2222) begin errors++; $display("FAIL lat_data got %h want %h", bus.MemData, 32'h2222_2222); end
        bus.MemInstruction = MEM_NOP;
        @(posedge clk); #1;
    endtask

    task automatic test_four_phase();
        int lat; logic [31:0] data; logic err;
        bus.MemInstruction = MEM_RD; bus.Addr = 9'h010;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
        end
        bus.Addr = 9'h020;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (bus.DataACKOut !== 1'b1) begin errors++; $display("FAIL fp_hold_ack%0d got %b want 1", i, bus.DataACKOut); end
            checks++; if (bus.MemData !== 32'h1234_5678) begin errors++; $display("FAIL fp_hold_data%0d got %h want %h", i, bus.MemData, 32'h1234_5678); end
        end
        bus.MemInstruction = MEM_NOP;
        @(posedge clk); #1;
        checks++; if (bus.DataACKOut !== 1'b0) begin errors++; $display("FAIL fp_nop_ack got %b want 0", bus.DataACKOut); end
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL fp_nop_busy got %b want 0", bus.Busy); end
        bus.MemInstruction = MEM_TO_GPR;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.MemData !== 32'h1234_5678) begin errors++; $display("FAIL fp_to_gpr_data got %h want %h", bus.MemData, 32'h1234_5678); end
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL fp_to_gpr_busy got %b want 0", bus.Busy); end
        bus.MemInstruction = MEM_NOP;
        @(posedge clk); #1;
        do_access(MEM_WR, 9'h030, 32'h3333_3333, lat, data, err);
        checks++; if (bus.MemData !== 32'h1234_5678) begin errors++; $display("FAIL fp_write_keeps_data got %h want %h", bus.MemData, 32'h1234_5678); end
    endtask

    task automatic test_wait_change();
        int lat; logic [31:0] data; logic err; int seen;
        do_access(MEM_WR, 9'h003, 32'h0000_3333, lat, data, err);
        bus.MemInstruction = MEM_WR; bus.Addr = 9'h002; bus.WrData = 32'hCAFE_0002;
        @(posedge clk); #1;
        bus.MemInstruction = MEM_RD; bus.Addr = 9'h003; bus.WrData = 32'h0000_0000;
        seen = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus.DataACKOut === 1'b1) begin seen = i; break; end
        end
        checks++; if (seen !== 3) begin errors++; $display("FAIL wc_ack_timing got %0d want 3", seen); end
        bus.MemInstruction = MEM_NOP;
        @(posedge clk); #1;
        do_access(MEM_RD, 9'h002, 32'd0, lat, data, err);
        checks++; if (data !== 32'hCAFE_0002) begin errors++; $display("FAIL wc_latched_write got %h want %h", data, 32'hCAFE_0002); end
        do_access(MEM_RD, 9'h003, 32'd0, lat, data, err);
        checks++; if (data !== 32'h0000_3333) begin errors++; $display("FAIL wc_other_untouched got %h want %h", data, 32'h0000_3333); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] data; logic err;
        do_access(MEM_WR, 9'h040, 32'h4040_4040, lat, data, err);
        do_access(MEM_WR, 9'h041, 32'h4141_4141, lat, data, err);
        checks++; if (lat !== 3) begin errors++; $display("FAIL b2b_latency got %0d want 3", lat); end
        do_access(MEM_RD, 9'h040, 32'd0, lat, data, err);
        checks++; if (data !== 32'h4040_4040) begin errors++; $display("FAIL b2b_rd0 got %h want %h", data, 32'h4040_4040); end
        do_access(MEM_RD, 9'h041, 32'd0, lat, data, err);
        checks++; if (data !== 32'h4141_4141) begin errors++; $display("FAIL b2b_rd1 got %h want %h", data, 32'h4141_4141); end
    endtask

    task automatic test_range();
        int lat; logic [31:0] data; logic err;
        logic        exp_err;
        logic [31:0] exp_hi, exp_lo;
`ifdef MEMRESP_RANGE_CHECK_EN
        exp_err = 1'b1; exp_hi = 32'hDEAD_BEEF; exp_lo = 32'h5555_0005;
`else
        exp_err = 1'b0; exp_hi = 32'h0BAD_0105; exp_lo = 32'h0BAD_0105;
`endif
        do_access(MEM_WR, 9'h005, 32'h5555_0005, lat, data, err);
        do_access(MEM_WR, 9'h105, 32'h0BAD_0105, lat, data, err);
        checks++; if (lat !== 3) begin errors++; $display("FAIL rng_wr_latency got %0d want 3", lat); end
        checks++; if (err !== exp_err) begin errors++; $display("FAIL rng_wr_err got %b want %b", err, exp_err); end
        checks++; if (bus.Err !== 1'b0) begin errors++; $display("FAIL rng_err_clear got %b want 0", bus.Err); end
        do_access(MEM_RD, 9'h105, 32'd0, lat, data, err);
        checks++; if (data !== exp_hi) begin errors++; $display("FAIL rng_rd_hi got %h want %h", data, exp_hi); end
        checks++; if (err !== exp_err) begin errors++; $display("FAIL rng_rd_err got %b want %b", err, exp_err); end
        do_access(MEM_RD, 9'h005, 32'd0, lat, data, err);
        checks++; if (data !== exp_lo) begin errors++; $display("FAIL rng_rd_lo got %h want %h", data, exp_lo); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rng_lo_err got %b want 0", err); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_latency();
        test_four_phase();
        test_wait_change();
        test_back_to_back();
        test_range();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
